// File: rtl/ysyx_23060025_ifu_prefetch_if.sv
// Icache request/response bus between the fetch stage and the instruction cache.
//   out_req_valid  : fetch stage -> icache, request valid
//   out_req_ready  : icache -> fetch stage, request accepted
//   out_req_addr   : fetch stage -> icache, request address
//   out_resp_valid : icache -> fetch stage, in-order response valid (always accepted)
//   out_resp_data  : icache -> fetch stage, response instruction
// master = fetch stage side, slave = icache side.
interface ysyx_23060025_ifu_prefetch_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  out_req_valid;
    logic                  out_req_ready;
    logic [ADDR_WIDTH-1:0] out_req_addr;
    logic                  out_resp_valid;
    logic [DATA_WIDTH-1:0] out_resp_data;

    modport master (
        output out_req_valid,
        output out_req_addr,
        input  out_req_ready,
        input  out_resp_valid,
        input  out_resp_data
    );

    modport slave (
        input  out_req_valid,
        input  out_req_addr,
        output out_req_ready,
        output out_resp_valid,
        output out_resp_data
    );
endinterface

// File: rtl/ysyx_23060025_ifu_prefetch.sv
// Pipelined instruction fetch stage with an FQ_DEPTH-entry prefetch queue and up to
// MAX_OUTSTANDING in-order icache requests. Redirects flush the queue and stale
// in-flight responses are discarded through a drop counter.
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   branch_*/jmp_*/csr_* : redirect requests (priority branch > jmp > csr)
//   ebreak_flag_i     : sticky halt, no further requests are issued
//   icache_io         : icache request/response bus (master side)
//   ds_allowin_i      : IDU accepts the head entry
//   fs_to_ds_valid_o, if_inst_o, if_pc_o : head entry towards the IDU
// Optional feature macro IFU_PERF_COUNTER_EN adds saturating 32-bit counters
// perf_fetch_cnt, perf_drop_cnt and perf_stall_cnt.
module ysyx_23060025_ifu_prefetch #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(32'h3000_0000),
    parameter int unsigned           FQ_DEPTH        = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        branch_request_i,
    input  logic                        branch_flag_i,
    input  logic [ADDR_WIDTH-1:0]       branch_target_i,
    input  logic                        jmp_flag_i,
    input  logic [ADDR_WIDTH-1:0]       jmp_target_i,
    input  logic                        csr_jmp_i,
    input  logic [ADDR_WIDTH-1:0]       csr_pc_i,
    input  logic                        ebreak_flag_i,
    ysyx_23060025_ifu_prefetch_if.master icache_io,
    input  logic                        ds_allowin_i,
    output logic                        fs_to_ds_valid_o,
    output logic [DATA_WIDTH-1:0]       if_inst_o,
    output logic [ADDR_WIDTH-1:0]       if_pc_o
`ifdef IFU_PERF_COUNTER_EN
    ,
    output logic [31:0]                 perf_fetch_cnt,
    output logic [31:0]                 perf_drop_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QPW = $clog2(FQ_DEPTH);
    localparam int unsigned QCW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  halt_q, halt_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

    // Addresses of in-flight requests, popped by every response (dropped or not).
    logic [ADDR_WIDTH-1:0] pcq_mem_q [MAX_OUTSTANDING];
    logic [PPW-1:0]        pcq_wr_q, pcq_wr_d;
    logic [PPW-1:0]        pcq_rd_q, pcq_rd_d;

    logic [ADDR_WIDTH-1:0] fq_pc_q   [FQ_DEPTH];
    logic [DATA_WIDTH-1:0] fq_inst_q [FQ_DEPTH];
    logic [QPW-1:0]        fq_wr_q, fq_wr_d;
    logic [QPW-1:0]        fq_rd_q, fq_rd_d;
    logic [QCW-1:0]        fq_cnt_q, fq_cnt_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  issue_ok;
    logic                  req_fire;
    logic                  resp_fire;
    logic                  resp_drop;
    logic                  q_push;
    logic                  q_pop;

    always_comb begin
        redirect = (branch_flag_i & branch_request_i) | jmp_flag_i | csr_jmp_i;
        if (branch_flag_i & branch_request_i) begin
            redirect_target = branch_target_i;
        end else if (jmp_flag_i) begin
            redirect_target = jmp_target_i;
        end else begin
            redirect_target = csr_pc_i;
        end

        // A request is only issued when a queue slot is reserved for its response.
        // Gating with reset keeps the request low while reset is asserted.
        issue_ok = reset & ~halt_q & ~redirect
                 & (32'(inflight_q) < MAX_OUTSTANDING)
                 & ((32'(inflight_q) + 32'(fq_cnt_q)) < FQ_DEPTH);
        req_fire  = issue_ok & icache_io.out_req_ready;
        resp_fire = icache_io.out_resp_valid;
        // A response arriving in the redirect cycle belongs to the old stream.
        resp_drop = redirect | (drop_cnt_q != '0);
        q_push    = resp_fire & ~resp_drop;

        fs_to_ds_valid_o = (fq_cnt_q != '0) & ~redirect;
        q_pop            = fs_to_ds_valid_o & ds_allowin_i;
    end

    assign icache_io.out_req_valid = issue_ok;
    assign icache_io.out_req_addr  = fetch_pc_q;
    assign if_inst_o               = fq_inst_q[fq_rd_q];
    assign if_pc_o                 = fq_pc_q[fq_rd_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_target;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        end

        halt_d     = halt_q | ebreak_flag_i;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);

        // Every request still in flight after the redirect cycle is stale. inflight_q
        // already includes requests pending a drop, so it is not added to drop_cnt_q.
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = inflight_q - CW'(resp_fire);
        end else if (resp_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        pcq_wr_d = pcq_wr_q;
        if (req_fire) begin
            pcq_wr_d = (pcq_wr_q == PPW'(MAX_OUTSTANDING - 1)) ? '0 : pcq_wr_q + PPW'(1);
        end
        pcq_rd_d = pcq_rd_q;
        if (resp_fire) begin
            pcq_rd_d = (pcq_rd_q == PPW'(MAX_OUTSTANDING - 1)) ? '0 : pcq_rd_q + PPW'(1);
        end

        if (redirect) begin
            fq_wr_d  = '0;
            fq_rd_d  = '0;
            fq_cnt_d = '0;
        end else begin
            fq_wr_d  = fq_wr_q + QPW'(q_push);
            fq_rd_d  = fq_rd_q + QPW'(q_pop);
            fq_cnt_d = fq_cnt_q + QCW'(q_push) - QCW'(q_pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            halt_q     <= 1'b0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            fq_wr_q    <= '0;
            fq_rd_q    <= '0;
            fq_cnt_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halt_q     <= halt_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            fq_wr_q    <= fq_wr_d;
            fq_rd_q    <= fq_rd_d;
            fq_cnt_q   <= fq_cnt_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                pcq_mem_q[i] <= '0;
            end
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                fq_pc_q[i]   <= '0;
                fq_inst_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
            end
            if (q_push) begin
                fq_pc_q[fq_wr_q]   <= pcq_mem_q[pcq_rd_q];
                fq_inst_q[fq_wr_q] <= icache_io.out_resp_data;
            end
        end
    end

    // Slot reservation must make a push into a full queue impossible.
    always @(posedge clock) begin
        if (reset) begin
            assert (!(q_push && (fq_cnt_q == QCW'(FQ_DEPTH))));
        end
    end

`ifdef IFU_PERF_COUNTER_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] perf_fetch_q, perf_drop_q, perf_stall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= sat_inc(perf_fetch_q, q_push);
            perf_drop_q  <= sat_inc(perf_drop_q, resp_fire & resp_drop);
            perf_stall_q <= sat_inc(perf_stall_q, ~fs_to_ds_valid_o & ~halt_q);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_23060025_ifu_prefetch.sv
module tb_ysyx_23060025_ifu_prefetch;
    localparam int unsigned FQ_DEPTH = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch_request_i = 1'b0;
    logic        branch_flag_i    = 1'b0;
    logic [31:0] branch_target_i  = '0;
    logic        jmp_flag_i       = 1'b0;
    logic [31:0] jmp_target_i     = '0;
    logic        csr_jmp_i        = 1'b0;
    logic [31:0] csr_pc_i         = '0;
    logic        ebreak_flag_i    = 1'b0;
    logic        ds_allowin_i     = 1'b0;
    logic        fs_to_ds_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
`ifdef IFU_PERF_COUNTER_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

    ysyx_23060025_ifu_prefetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) icache_if ();

    ysyx_23060025_ifu_prefetch #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .RESET_PC       (RESET_PC),
        .FQ_DEPTH       (FQ_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .branch_request_i(branch_request_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .jmp_flag_i      (jmp_flag_i),
        .jmp_target_i    (jmp_target_i),
        .csr_jmp_i       (csr_jmp_i),
        .csr_pc_i        (csr_pc_i),
        .ebreak_flag_i   (ebreak_flag_i),
        .icache_io       (icache_if),
        .ds_allowin_i    (ds_allowin_i),
        .fs_to_ds_valid_o(fs_to_ds_valid_o),
        .if_inst_o       (if_inst_o),
        .if_pc_o         (if_pc_o)
`ifdef IFU_PERF_COUNTER_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_drop_cnt   (perf_drop_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int ready_pct = 100;
    int resp_pct  = 100;
    logic last_fs;

    // Reference model: fetch pc, halt flag, in-flight requests tagged stale or live,
    // and the instructions visible to the IDU.
    logic [31:0] m_pc;
    bit          m_halt;
    logic [31:0] inf_pc[$];
    bit          inf_stale[$];
    logic [31:0] fq_pc[$];
    logic [31:0] fq_inst[$];
    // Icache model: addresses it has accepted from the DUT, answered in order.
    logic [31:0] ic_q[$];
    // Observed DUT traffic.
    logic [31:0] dut_reqs[$];
    logic [31:0] dut_deliv[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
        inf_pc.delete();
        inf_stale.delete();
        fq_pc.delete();
        fq_inst.delete();
        ic_q.delete();
    endtask

    task automatic clear_flags();
        branch_request_i = 1'b0;
        branch_flag_i    = 1'b0;
        jmp_flag_i       = 1'b0;
        csr_jmp_i        = 1'b0;
        ebreak_flag_i    = 1'b0;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step();
        bit          redirect, exp_req, exp_fs, fire, resp, pop, rstale;
        logic [31:0] tgt, rpc;
        resp = (ic_q.size() > 0) && ($urandom_range(99) < resp_pct);
        icache_if.out_resp_valid = resp;
        icache_if.out_resp_data  = resp ? inst_of(ic_q[0]) : 32'h0;
        icache_if.out_req_ready  = ($urandom_range(99) < ready_pct);
        #1;
        redirect = (branch_flag_i && branch_request_i) || jmp_flag_i || csr_jmp_i;
        tgt = (branch_flag_i && branch_request_i) ? branch_target_i :
              jmp_flag_i ? jmp_target_i : csr_pc_i;
        exp_req = !m_halt && !redirect && (inf_pc.size() < MAX_OUT)
                  && (inf_pc.size() + fq_pc.size() < FQ_DEPTH);
        exp_fs = (fq_pc.size() > 0) && !redirect;
        check("req_valid", 32'(icache_if.out_req_valid), 32'(exp_req));
        if (exp_req) check("req_addr", icache_if.out_req_addr, m_pc);
        check("fs_valid", 32'(fs_to_ds_valid_o), 32'(exp_fs));
        if (exp_fs) begin
            check("if_pc", if_pc_o, fq_pc[0]);
            check("if_inst", if_inst_o, fq_inst[0]);
        end
        last_fs = fs_to_ds_valid_o;
        if (icache_if.out_req_valid && icache_if.out_req_ready) begin
            dut_reqs.push_back(icache_if.out_req_addr);
            ic_q.push_back(icache_if.out_req_addr);
        end
        if (fs_to_ds_valid_o && ds_allowin_i) dut_deliv.push_back(if_pc_o);
        if (resp) void'(ic_q.pop_front());

        fire = exp_req && icache_if.out_req_ready;
        pop  = exp_fs && ds_allowin_i;
        if (pop) begin
            void'(fq_pc.pop_front());
            void'(fq_inst.pop_front());
        end
        if (resp) begin
            rpc    = inf_pc.pop_front();
            rstale = inf_stale.pop_front();
            if (!rstale && !redirect) begin
                fq_pc.push_back(rpc);
                fq_inst.push_back(inst_of(rpc));
            end
        end
        if (fire) begin
            inf_pc.push_back(m_pc);
            inf_stale.push_back(1'b0);
        end
        if (redirect) begin
            foreach (inf_stale[i]) inf_stale[i] = 1'b1;
            fq_pc.delete();
            fq_inst.delete();
            m_pc = tgt;
        end else if (fire) begin
            m_pc = m_pc + 32'd4;
        end
        if (ebreak_flag_i) m_halt = 1'b1;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_n;
        icache_if.out_req_ready  = 1'b0;
        icache_if.out_resp_valid = 1'b0;
        icache_if.out_resp_data  = '0;
        model_reset();

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_req_valid", 32'(icache_if.out_req_valid), 32'd0);
        check("rst_fs_valid", 32'(fs_to_ds_valid_o), 32'd0);
        check("rst_if_inst", if_inst_o, 32'd0);
        check("rst_if_pc", if_pc_o, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // 1: streaming fetch, one instruction per cycle once filled
        ds_allowin_i = 1'b1;
        ready_pct = 100;
        resp_pct  = 100;
        for (int i = 0; i < 4; i++) step();
        dut_deliv.delete();
        for (int i = 0; i < 8; i++) step();
        check("steady_rate", 32'(dut_deliv.size()), 32'd8);
        check("first_req", dut_reqs[0], 32'h3000_0000);
        check("second_req", dut_reqs[1], 32'h3000_0004);
        check("third_req", dut_reqs[2], 32'h3000_0008);

        // 2: IDU stalled, queue fills, then drains without loss
        ds_allowin_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_no_issue", 32'(icache_if.out_req_valid), 32'd0);
        ready_pct = 0;
        ds_allowin_i = 1'b1;
        dut_deliv.delete();
        for (int i = 0; i < 6; i++) step();
        check("drain_count", 32'(dut_deliv.size()), 32'd4);
        check("drain_span", dut_deliv[3] - dut_deliv[0], 32'd12);

        // 3: jump with two requests in flight
        ready_pct = 100;
        resp_pct  = 0;
        for (int i = 0; i < 3; i++) step();
        jmp_flag_i   = 1'b1;
        jmp_target_i = 32'h3000_0100;
        step();
        check("redirect_fs_low", 32'(last_fs), 32'd0);
        clear_flags();
        resp_pct = 100;
        dut_deliv.delete();
        for (int i = 0; i < 20 && dut_deliv.size() == 0; i++) step();
        check("jmp_delivered", 32'(dut_deliv.size() > 0), 32'd1);
        check("jmp_first_pc", dut_deliv[0], 32'h3000_0100);

        // 4: all redirect sources together, coincident with a response
        resp_pct = 0;
        for (int i = 0; i < 2; i++) step();
        resp_pct         = 100;
        branch_flag_i    = 1'b1;
        branch_request_i = 1'b1;
        branch_target_i  = 32'h3000_0200;
        jmp_flag_i       = 1'b1;
        jmp_target_i     = 32'h3000_0300;
        csr_jmp_i        = 1'b1;
        csr_pc_i         = 32'h3000_0400;
        dut_reqs.delete();
        dut_deliv.delete();
        step();
        clear_flags();
        for (int i = 0; i < 20 && dut_deliv.size() == 0; i++) step();
        check("prio_req", dut_reqs[0], 32'h3000_0200);
        check("prio_delivered", dut_deliv[0], 32'h3000_0200);

        // 5: fetch address wrap
        jmp_flag_i   = 1'b1;
        jmp_target_i = 32'hFFFF_FFF8;
        step();
        clear_flags();
        dut_reqs.delete();
        for (int i = 0; i < 6; i++) step();
        check("wrap_reqs", 32'(dut_reqs.size() >= 3), 32'd1);
        check("wrap_a", dut_reqs[0], 32'hFFFF_FFF8);
        check("wrap_b", dut_reqs[1], 32'hFFFF_FFFC);
        check("wrap_c", dut_reqs[2], 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            ready_pct        = 70;
            resp_pct         = 60;
            ds_allowin_i     = ($urandom_range(99) < 75);
            branch_flag_i    = ($urandom_range(9) == 0);
            branch_request_i = $urandom_range(1) == 1;
            branch_target_i  = $urandom() & 32'hFFFF_FFFC;
            jmp_flag_i       = ($urandom_range(19) == 0);
            jmp_target_i     = $urandom() & 32'hFFFF_FFFC;
            csr_jmp_i        = ($urandom_range(24) == 0);
            csr_pc_i         = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        clear_flags();

        // 6a: reset in the middle of traffic
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req_valid", 32'(icache_if.out_req_valid), 32'd0);
        check("mid_rst_fs_valid", 32'(fs_to_ds_valid_o), 32'd0);
        check("mid_rst_if_inst", if_inst_o, 32'd0);
        check("mid_rst_if_pc", if_pc_o, 32'd0);
        icache_if.out_resp_valid = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        ready_pct = 100;
        resp_pct  = 100;
        ds_allowin_i = 1'b1;
        dut_reqs.delete();
        step();
        check("restart_pc", dut_reqs[0], RESET_PC);

        // 6b: ebreak with requests in flight
        for (int i = 0; i < 6; i++) step();
        resp_pct = 0;
        for (int i = 0; i < 2; i++) step();
        exp_n = fq_pc.size();
        foreach (inf_stale[i]) if (!inf_stale[i]) exp_n++;
        ebreak_flag_i = 1'b1;
        ready_pct     = 0;
        ds_allowin_i  = 1'b0;
        step();
        clear_flags();
        ready_pct    = 100;
        resp_pct     = 100;
        ds_allowin_i = 1'b1;
        dut_reqs.delete();
        dut_deliv.delete();
        for (int i = 0; i < 10; i++) step();
        check("halt_no_issue", 32'(dut_reqs.size()), 32'd0);
        check("halt_drain", 32'(dut_deliv.size()), 32'(exp_n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
